// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - time sources in, scanned segment/digit/indicator outputs
interface display_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              Sel;
  logic              Edit;
  logic [1:0]        Field;
  logic [4*NDIG-1:0] CurTime;
  logic [4*NDIG-1:0] SetTime;
  logic [2:0]        CurDay;
  logic [2:0]        SetDay;
  logic              CurPM;
  logic              SetPM;
  logic [6:0]        Seg;
  logic [NDIG-1:0]   DigEn;
  logic [6:0]        Days;
  logic              AM;
  logic              PM;
  logic              DBlink;

  modport master (
    output Sel, Edit, Field, CurTime, SetTime, CurDay, SetDay, CurPM, SetPM,
    input  Seg, DigEn, Days, AM, PM, DBlink
  );

  modport slave (
    input  Sel, Edit, Field, CurTime, SetTime, CurDay, SetDay, CurPM, SetPM,
    output Seg, DigEn, Days, AM, PM, DBlink
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed BCD display scanner with per-frame snapshot and field blink
module display_scan_ctrl #(
  parameter int              NDIG      = 4,
  parameter int              SCAN_DIV  = 1024,
  parameter int              BLINK_DIV = 128,
  parameter logic [NDIG-1:0] MIN_MASK  = 4'b0011,
  parameter logic [NDIG-1:0] HR_MASK   = 4'b1100,
  parameter bit              LZB       = 1'b1
) (
  input logic                Clk,
  input logic                Clr,
  display_scan_ctrl_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = 4 * NDIG;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  logic [PW-1:0]   pre_q, pre_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            upd_q, upd_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic            phase_q, phase_d;
  logic            edit_prev_q, edit_prev_d;
  logic [1:0]      field_prev_q, field_prev_d;
  logic [TW-1:0]   snap_time_q, snap_time_d;
  logic [2:0]      snap_day_q, snap_day_d;
  logic            snap_pm_q, snap_pm_d;
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] dig_en_q, dig_en_d;
  logic [6:0]      days_q, days_d;
  logic            am_q, am_d;
  logic            pm_q, pm_d;
  logic            dblink_q, dblink_d;

  logic            tick;
  logic            frame_wrap;
  logic            restart;
  logic            hide;
  logic [3:0]      cur_dig;
  logic [NDIG-1:0] field_mask;

  always_comb begin
    tick       = (pre_q == PRE_LAST);
    frame_wrap = tick && (idx_q == IDX_LAST);
    restart    = (bus.Edit != edit_prev_q) || (bus.Field != field_prev_q);

    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    upd_d = tick;

    // Whole-frame snapshot keeps a digit rollover from tearing across slots
    snap_time_d = snap_time_q;
    snap_day_d  = snap_day_q;
    snap_pm_d   = snap_pm_q;
    if (frame_wrap) begin
      snap_time_d = bus.Sel ? bus.SetTime : bus.CurTime;
      snap_day_d  = bus.Sel ? bus.SetDay  : bus.CurDay;
      snap_pm_d   = bus.Sel ? bus.SetPM   : bus.CurPM;
    end

    blk_d   = blk_q;
    phase_d = phase_q;
    if (restart) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (blk_q == BLK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end
    edit_prev_d  = bus.Edit;
    field_prev_d = bus.Field;

    // Follows the next phase so a field switch clears the indicator at once
    dblink_d = bus.Edit & phase_d;

    cur_dig = 4'(snap_time_q >> {idx_q, 2'b00});
    case (bus.Field)
      2'b01:   field_mask = MIN_MASK;
      2'b10:   field_mask = HR_MASK;
      default: field_mask = '0;
    endcase
    hide = bus.Edit && phase_q && field_mask[idx_q];

    seg_d    = seg_q;
    dig_en_d = dig_en_q;
    days_d   = days_q;
    am_d     = am_q;
    pm_d     = pm_q;
    if (upd_q) begin
      dig_en_d = NDIG'(1) << idx_q;
      if (hide || (LZB && idx_q == IDX_LAST && cur_dig == 4'd0)) begin
        seg_d = 7'b0000000;
      end else begin
        seg_d = seg_decode(cur_dig);
      end
      if (snap_day_q == 3'd7 || (bus.Edit && bus.Field == 2'b11 && phase_q)) begin
        days_d = 7'b0000000;
      end else begin
        days_d = 7'b0000001 << snap_day_q;
      end
      if (bus.Edit && bus.Field == 2'b10 && phase_q) begin
        am_d = 1'b0;
        pm_d = 1'b0;
      end else begin
        am_d = ~snap_pm_q;
        pm_d = snap_pm_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      pre_q        <= '0;
      idx_q        <= '0;
      upd_q        <= 1'b0;
      blk_q        <= '0;
      phase_q      <= 1'b0;
      edit_prev_q  <= 1'b0;
      field_prev_q <= 2'b00;
      snap_time_q  <= '0;
      snap_day_q   <= 3'd0;
      snap_pm_q    <= 1'b0;
      seg_q        <= 7'b0000000;
      dig_en_q     <= '0;
      days_q       <= 7'b0000000;
      am_q         <= 1'b0;
      pm_q         <= 1'b0;
      dblink_q     <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      upd_q        <= upd_d;
      blk_q        <= blk_d;
      phase_q      <= phase_d;
      edit_prev_q  <= edit_prev_d;
      field_prev_q <= field_prev_d;
      snap_time_q  <= snap_time_d;
      snap_day_q   <= snap_day_d;
      snap_pm_q    <= snap_pm_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      days_q       <= days_d;
      am_q         <= am_d;
      pm_q         <= pm_d;
      dblink_q     <= dblink_d;
    end
  end

  assign bus.Seg    = seg_q;
  assign bus.DigEn  = dig_en_q;
  assign bus.Days   = days_q;
  assign bus.AM     = am_q;
  assign bus.PM     = pm_q;
  assign bus.DBlink = dblink_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;
  localparam int         NDIG      = 4;
  localparam int         SCAN_DIV  = 2;
  localparam int         BLINK_DIV = 4;
  localparam logic [3:0] MIN_MASK  = 4'b0011;
  localparam logic [3:0] HR_MASK   = 4'b1100;
  localparam bit         LZB       = 1'b1;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic [6:0] days;
    logic       am;
    logic       pm;
    logic       dblink;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  display_scan_ctrl #(
    .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
    .MIN_MASK(MIN_MASK), .HR_MASK(HR_MASK), .LZB(LZB)
  ) dut (
    .Clk(clk),
    .Clr(rst_n),
    .bus(bus)
  );

  // Reference model: counts clocks and scan ticks since reset / since the last edit change
  int         cyc, ticks, bt, m_idx;
  bit         prev_tick, m_tick, m_ph;
  logic [15:0] m_time;
  logic [2:0] m_day;
  logic       m_pm, m_edit;
  logic [1:0] m_field;
  logic [3:0] m_v;
  out_t       m_out;
  out_t       sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; ticks = 0; bt = 0; prev_tick = 0;
      m_time = '0; m_day = '0; m_pm = 0; m_edit = 0; m_field = 0;
      m_out = '0;
      sb.delete();
    end else begin
      m_tick = (cyc % SCAN_DIV) == SCAN_DIV - 1;
      m_ph = ((bt / BLINK_DIV) % 2) == 1;
      if (prev_tick) begin
        m_idx = ticks % NDIG;
        m_v = m_time[4*m_idx +: 4];
        m_out.dig = 4'b0001 << m_idx;
        if (bus.Edit && m_ph && ((bus.Field == 2'b01 && MIN_MASK[m_idx]) ||
                                 (bus.Field == 2'b10 && HR_MASK[m_idx])))
          m_out.seg = '0;
        else if (LZB && m_idx == NDIG - 1 && m_v == 4'd0)
          m_out.seg = '0;
        else
          m_out.seg = SEG_TAB[m_v];
        if (m_day == 3'd7 || (bus.Edit && bus.Field == 2'b11 && m_ph))
          m_out.days = '0;
        else
          m_out.days = 7'b0000001 << m_day;
        if (bus.Edit && bus.Field == 2'b10 && m_ph) begin
          m_out.am = 1'b0; m_out.pm = 1'b0;
        end else begin
          m_out.am = ~m_pm; m_out.pm = m_pm;
        end
      end
      if (m_tick) begin
        ticks++;
        if (ticks % NDIG == 0) begin
          m_time = bus.Sel ? bus.SetTime : bus.CurTime;
          m_day  = bus.Sel ? bus.SetDay  : bus.CurDay;
          m_pm   = bus.Sel ? bus.SetPM   : bus.CurPM;
        end
      end
      if (bus.Edit !== m_edit || bus.Field !== m_field) bt = 0;
      else if (m_tick) bt++;
      m_out.dblink = bus.Edit && (((bt / BLINK_DIV) % 2) == 1);
      m_edit = bus.Edit; m_field = bus.Field;
      prev_tick = m_tick;
      cyc++;
      sb.push_back(m_out);
    end
  end

  out_t exp_o, act_o;
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      exp_o = sb.pop_front();
      act_o = {bus.Seg, bus.DigEn, bus.Days, bus.AM, bus.PM, bus.DBlink};
      total++;
      if (act_o !== exp_o) begin
        bad++;
        $display("FAIL outputs t=%0t seg=%b/%b dig=%b/%b days=%b/%b am=%b/%b pm=%b/%b dblink=%b/%b (got/want)",
                 $time, act_o.seg, exp_o.seg, act_o.dig, exp_o.dig, act_o.days, exp_o.days,
                 act_o.am, exp_o.am, act_o.pm, exp_o.pm, act_o.dblink, exp_o.dblink);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_zero(input string name);
    logic [20:0] v;
    v = {bus.Seg, bus.DigEn, bus.Days, bus.AM, bus.PM, bus.DBlink};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s got=%b want=0", name, v);
    end
  endtask

  function automatic logic [15:0] rand_time();
    logic [15:0] t;
    for (int i = 0; i < 4; i++) t[4*i +: 4] = 4'($urandom_range(0, 11));
    return t;
  endfunction

  int n;

  initial begin
    bus.Sel = 0; bus.Edit = 0; bus.Field = 2'b00;
    bus.CurTime = 16'h1234; bus.SetTime = 16'h0000;
    bus.CurDay = 3'd2; bus.SetDay = 3'd0; bus.CurPM = 0; bus.SetPM = 0;
    #23;
    check_zero("reset_state");
    rst_n = 1'b1;
    step(40);

    bus.CurTime = 16'h0905;
    step(20);
    bus.CurTime = 16'h09A5;
    step(20);
    step(3);
    bus.CurTime = 16'h5678;
    step(20);

    // Hours blink, then switch to minutes while blinked off
    bus.Edit = 1; bus.Field = 2'b10;
    n = 0;
    while (bus.DBlink !== 1'b1 && n < 60) begin step(); n++; end
    total++;
    if (bus.DBlink !== 1'b1) begin
      bad++;
      $display("FAIL dblink_rise got=%b want=1", bus.DBlink);
    end
    step(3);
    bus.Field = 2'b01;
    step(30);
    bus.Field = 2'b11;
    step(30);
    bus.Edit = 0;
    step(10);

    // Frame wrap coinciding with a field change
    n = 0;
    while ((cyc % (SCAN_DIV * NDIG)) != SCAN_DIV * NDIG - 1 && n < 20) begin step(); n++; end
    bus.Edit = 1; bus.Field = 2'b10; bus.Sel = 1;
    bus.SetTime = 16'h1159; bus.SetDay = 3'd3; bus.SetPM = 1;
    step(40);
    bus.Edit = 0;
    step(20);

    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 9) == 0) bus.CurTime = rand_time();
      if ($urandom_range(0, 9) == 0) bus.SetTime = rand_time();
      if ($urandom_range(0, 19) == 0) bus.CurDay = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bus.SetDay = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.CurPM = ~bus.CurPM;
      if ($urandom_range(0, 15) == 0) bus.SetPM = ~bus.SetPM;
      if ($urandom_range(0, 29) == 0) bus.Sel = ~bus.Sel;
      if ($urandom_range(0, 39) == 0) begin
        bus.Edit = 1'($urandom_range(0, 1));
        bus.Field = 2'($urandom_range(0, 3));
      end
      step();
    end

    // Asynchronous reset between clock edges
    bus.Sel = 1; bus.SetDay = 3'd3; bus.SetPM = 1; bus.Edit = 0;
    step(21);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    step(2);
    check_zero("reset_hold");
    rst_n = 1'b1;
    step(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
